// File: rtl/control_unit_pkg.sv
// Shared definitions for the control unit: opcodes, state encoding, ALU selects,
// the registered control-output bundle and the decode/next-state helpers.
package control_unit_pkg;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned PC_W    = 7;
  localparam int unsigned DADDR_W = 8;
  localparam int unsigned RADDR_W = 4;
  localparam int unsigned ALU_S_W = 3;
  localparam int unsigned STATE_W = 4;
  localparam int unsigned OP_W    = 4;

  localparam logic [OP_W-1:0] OP_NOOP  = 4'h0;
  localparam logic [OP_W-1:0] OP_STORE = 4'h1;
  localparam logic [OP_W-1:0] OP_LOAD  = 4'h2;
  localparam logic [OP_W-1:0] OP_ADD   = 4'h3;
  localparam logic [OP_W-1:0] OP_SUB   = 4'h4;
  localparam logic [OP_W-1:0] OP_HALT  = 4'h5;

  localparam logic [ALU_S_W-1:0] ALU_ADD = 3'b011;
  localparam logic [ALU_S_W-1:0] ALU_SUB = 3'b010;
  localparam logic [ALU_S_W-1:0] ALU_CLR = 3'b000;

  typedef enum logic [STATE_W-1:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_ST_RD  = 4'd3,
    S_ST_WR  = 4'd4,
    S_LD_RD  = 4'd5,
    S_LD_WR  = 4'd6,
    S_ALU_RD = 4'd7,
    S_ALU_WR = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  typedef struct packed {
    logic [DADDR_W-1:0] d_addr;
    logic               d_wr;
    logic [RADDR_W-1:0] rf_a_addr;
    logic [RADDR_W-1:0] rf_b_addr;
    logic               rf_wen_a;
    logic               rf_wen_b;
    logic [ALU_S_W-1:0] alu_s;
  } ctrl_t;

  // Control outputs as a pure function of a state and an instruction word.
  function automatic ctrl_t decode_ctrl(state_t s, logic [DATA_W-1:0] ir);
    ctrl_t c;
    c = '0;
    case (s)
      S_ST_RD, S_ST_WR, S_LD_RD, S_LD_WR: begin
        c.d_addr    = ir[11:4];
        c.rf_a_addr = ir[3:0];
      end
      S_ALU_RD, S_ALU_WR: begin
        c.rf_a_addr = ir[11:8];
        c.rf_b_addr = ir[7:4];
        c.alu_s     = (ir[15:12] == OP_SUB) ? ALU_SUB : ALU_ADD;
      end
      default: c.alu_s = ALU_CLR;
    endcase
    c.d_wr     = (s == S_ST_WR);
    c.rf_wen_a = (s == S_LD_WR);
    c.rf_wen_b = (s == S_ALU_WR);
    return c;
  endfunction

  function automatic state_t next_state(state_t s, logic [OP_W-1:0] op, logic step);
    state_t n;
    n = S_INIT;
    case (s)
      S_INIT:   n = S_FETCH;
      S_FETCH:  n = step ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_STORE:       n = S_ST_RD;
          OP_LOAD:        n = S_LD_RD;
          OP_ADD, OP_SUB: n = S_ALU_RD;
          OP_HALT:        n = S_HALT;
          default:        n = S_FETCH;
        endcase
      end
      S_ST_RD:  n = S_ST_WR;
      S_ST_WR:  n = S_FETCH;
      S_LD_RD:  n = S_LD_WR;
      S_LD_WR:  n = S_FETCH;
      S_ALU_RD: n = S_ALU_WR;
      S_ALU_WR: n = S_FETCH;
      S_HALT:   n = S_HALT;
      default:  n = S_INIT;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Bus between the control unit and the instruction ROM, data RAM,
// register file and ALU.
interface control_unit_if;
  import control_unit_pkg::*;

  logic [DATA_W-1:0]  I_data;
  logic [PC_W-1:0]    I_addr;
  logic [DADDR_W-1:0] D_addr;
  logic               D_wr;
  logic [RADDR_W-1:0] RF_A_addr;
  logic [RADDR_W-1:0] RF_B_addr;
  logic               RF_WenA;
  logic               RF_WenB;
  logic [ALU_S_W-1:0] ALU_s;

  modport master (
    input  I_data,
    output I_addr, D_addr, D_wr, RF_A_addr, RF_B_addr, RF_WenA, RF_WenB, ALU_s
  );

  modport slave (
    output I_data,
    input  I_addr, D_addr, D_wr, RF_A_addr, RF_B_addr, RF_WenA, RF_WenB, ALU_s
  );
endinterface

// File: rtl/control_unit_program_counter.sv
// PC and instruction register; both load together while decoding, PC wraps mod 128.
module ProgramCounter
  import control_unit_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Ld_IR,
  input  logic              Inc,
  input  logic [DATA_W-1:0] I_data,
  output logic [PC_W-1:0]   PC,
  output logic [DATA_W-1:0] IR
);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      PC <= '0;
      IR <= '0;
    end else begin
      if (Ld_IR) IR <= I_data;
      if (Inc)   PC <= PC + PC_W'(1);
    end
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control unit sequencing a ROM/RAM/register-file/ALU datapath.
// Optional feature: define SINGLE_STEP_EN to add a Step input gating FETCH.
module control_unit
  import control_unit_pkg::*;
(
  input  logic                Clk,
  input  logic                Reset,
`ifdef SINGLE_STEP_EN
  input  logic                Step,
`endif
  control_unit_if.master      bus,
  output logic [PC_W-1:0]     PC_out,
  output logic [DATA_W-1:0]   IR_out,
  output logic [STATE_W-1:0]  State_out,
  output logic                Halted
);

  state_t            state;
  state_t            state_nx;
  ctrl_t             ctrl;
  logic [PC_W-1:0]   pc;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] ir_nx;
  logic              in_decode;
  logic              step_ok;

`ifdef SINGLE_STEP_EN
  assign step_ok = Step;
`else
  assign step_ok = 1'b1;
`endif

  assign in_decode = (state == S_DECODE);

  ProgramCounter u_pc (
    .Clk    (Clk),
    .Reset  (Reset),
    .Ld_IR  (in_decode),
    .Inc    (in_decode),
    .I_data (bus.I_data),
    .PC     (pc),
    .IR     (ir)
  );

  // IR value that will be visible alongside the next state.
  always_comb begin
    state_nx = next_state(state, bus.I_data[15:12], step_ok);
    ir_nx    = in_decode ? bus.I_data : ir;
  end

  // Outputs are registered from the upcoming state so they always equal decode(state, IR).
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= S_INIT;
      ctrl   <= '0;
      Halted <= 1'b0;
    end else begin
      state  <= state_nx;
      ctrl   <= decode_ctrl(state_nx, ir_nx);
      Halted <= (state_nx == S_HALT);
    end
  end

  assign bus.I_addr    = pc;
  assign bus.D_addr    = ctrl.d_addr;
  assign bus.D_wr      = ctrl.d_wr;
  assign bus.RF_A_addr = ctrl.rf_a_addr;
  assign bus.RF_B_addr = ctrl.rf_b_addr;
  assign bus.RF_WenA   = ctrl.rf_wen_a;
  assign bus.RF_WenB   = ctrl.rf_wen_b;
  assign bus.ALU_s     = ctrl.alu_s;

  assign PC_out    = pc;
  assign IR_out    = ir;
  assign State_out = STATE_W'(state);

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: ROM/RAM/register-file/ALU models plus a write scoreboard.
// Define SINGLE_STEP_EN to build and exercise the Step input.
module tb_control_unit;
  import control_unit_pkg::*;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
`ifdef SINGLE_STEP_EN
  logic Step = 1'b1;
`endif

  always #5 Clk = ~Clk;

  control_unit_if bus ();

  logic [6:0]  pc_out;
  logic [15:0] ir_out;
  logic [3:0]  state_out;
  logic        halted;

  control_unit dut (
    .Clk       (Clk),
    .Reset     (Reset),
`ifdef SINGLE_STEP_EN
    .Step      (Step),
`endif
    .bus       (bus),
    .PC_out    (pc_out),
    .IR_out    (ir_out),
    .State_out (state_out),
    .Halted    (halted)
  );

  // Datapath models, also the only writers of their arrays (preload port included).
  logic [15:0] rom  [128];
  logic [15:0] dmem [256];
  logic [15:0] rf   [16];
  logic [15:0] ram_q;
  logic [15:0] rf_a, rf_b, alu_out;
  logic        pl_en = 1'b0;
  logic [1:0]  pl_sel = '0;
  logic [7:0]  pl_addr = '0;
  logic [15:0] pl_data = '0;

  assign rf_a = rf[bus.RF_A_addr];
  assign rf_b = rf[bus.RF_B_addr];

  always_comb begin
    alu_out = '0;
    if (bus.ALU_s == 3'b011)      alu_out = rf_a + rf_b;
    else if (bus.ALU_s == 3'b010) alu_out = rf_a - rf_b;
  end

  always @(posedge Clk) begin
    if (pl_en) begin
      case (pl_sel)
        2'd0:    rom[pl_addr[6:0]] <= pl_data;
        2'd1:    dmem[pl_addr] <= pl_data;
        default: rf[pl_addr[3:0]] <= pl_data;
      endcase
    end else begin
      if (bus.D_wr)    dmem[bus.D_addr] <= rf_a;
      if (bus.RF_WenA) rf[bus.RF_A_addr] <= ram_q;
      if (bus.RF_WenB) rf[bus.RF_B_addr] <= alu_out;
    end
    bus.I_data <= rom[bus.I_addr];
    ram_q      <= dmem[bus.D_addr];
  end

  typedef struct packed {
    logic [1:0]  kind;
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_act, mon_exp;
  int  checks = 0;
  int  failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic wr_t mk(input logic [1:0] k, input logic [7:0] a, input logic [15:0] d);
    wr_t w;
    w.kind = k;
    w.addr = a;
    w.data = d;
    return w;
  endfunction

  // Monitor: every write the DUT issues is matched against the next expected one.
  always @(negedge Clk) begin
    if (bus.D_wr || bus.RF_WenA || bus.RF_WenB) begin
      check("single_write_en", 32'(bus.D_wr) + 32'(bus.RF_WenA) + 32'(bus.RF_WenB), 32'd1);
      mon_act.kind = bus.D_wr ? 2'd0 : (bus.RF_WenA ? 2'd1 : 2'd2);
      mon_act.addr = bus.D_wr ? bus.D_addr :
                     (bus.RF_WenA ? {4'b0, bus.RF_A_addr} : {4'b0, bus.RF_B_addr});
      mon_act.data = bus.D_wr ? rf_a : (bus.RF_WenA ? ram_q : alu_out);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got 0x%0h expected no write", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        check("write_txn", 32'(mon_act), 32'(mon_exp));
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic preload(input logic [1:0] sel, input logic [7:0] addr, input logic [15:0] data);
    pl_en   = 1'b1;
    pl_sel  = sel;
    pl_addr = addr;
    pl_data = data;
    tick();
    pl_en   = 1'b0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 128; i++) preload(2'd0, 8'(i), 16'h0000);
  endtask

  // Leaves the DUT in its first FETCH cycle.
  task automatic start();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    tick();
  endtask

  // seq holds n states, first state in the most significant used nibble.
  task automatic expect_states(input string name, input logic [31:0] seq, input int n);
    for (int i = 0; i < n; i++) begin
      check(name, 32'(state_out), 32'(seq[4*(n-1-i) +: 4]));
      if (i < n - 1) tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got time limit expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int bad;
    // Reset state
    Reset = 1'b1;
    tick();
    check("rst_state", 32'(state_out), 32'd0);
    check("rst_pc", 32'(pc_out), 32'd0);
    check("rst_ir", 32'(ir_out), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_bus", 32'({bus.D_addr, bus.D_wr, bus.RF_A_addr, bus.RF_B_addr,
                          bus.RF_WenA, bus.RF_WenB, bus.ALU_s}), 32'd0);

    // LOAD R3 <- D[1A]
    clear_rom();
    preload(2'd0, 8'h00, 16'h21A3);
    preload(2'd1, 8'h1A, 16'hBEEF);
    exp_q.push_back(mk(2'd1, 8'h03, 16'hBEEF));
    start();
    expect_states("load_seq", 32'h1256, 4);
    check("load_wen_a", 32'(bus.RF_WenA), 32'd1);
    check("load_d_addr", 32'(bus.D_addr), 32'h1A);
    check("load_rf_a", 32'(bus.RF_A_addr), 32'd3);
    tick();
    check("load_pc", 32'(pc_out), 32'd1);
    check("load_r3", 32'(rf[3]), 32'hBEEF);

    // ADD R5 <- R2 + R5
    Reset = 1'b1;
    preload(2'd0, 8'h00, 16'h3250);
    preload(2'd2, 8'h02, 16'd7);
    preload(2'd2, 8'h05, 16'd9);
    exp_q.push_back(mk(2'd2, 8'h05, 16'd16));
    start();
    expect_states("add_seq", 32'h1278, 4);
    check("add_alu_s", 32'(bus.ALU_s), 32'd3);
    check("add_rf_a", 32'(bus.RF_A_addr), 32'd2);
    check("add_rf_b", 32'(bus.RF_B_addr), 32'd5);
    check("add_wen_b", 32'(bus.RF_WenB), 32'd1);
    tick();
    check("add_r5", 32'(rf[5]), 32'd16);

    // SUB R5 <- R2 - R5
    Reset = 1'b1;
    preload(2'd0, 8'h00, 16'h4250);
    preload(2'd2, 8'h05, 16'd9);
    exp_q.push_back(mk(2'd2, 8'h05, 16'hFFFE));
    start();
    expect_states("sub_seq", 32'h1278, 4);
    check("sub_alu_s", 32'(bus.ALU_s), 32'd2);
    tick();
    check("sub_r5", 32'(rf[5]), 32'hFFFE);

    // STORE R6 -> D[40]
    Reset = 1'b1;
    preload(2'd0, 8'h00, 16'h1406);
    preload(2'd2, 8'h06, 16'h1234);
    exp_q.push_back(mk(2'd0, 8'h40, 16'h1234));
    start();
    expect_states("store_seq", 32'h1234, 4);
    check("store_d_wr", 32'(bus.D_wr), 32'd1);
    check("store_d_addr", 32'(bus.D_addr), 32'h40);
    check("store_rf_a", 32'(bus.RF_A_addr), 32'd6);
    tick();
    check("store_mem", 32'(dmem[8'h40]), 32'h1234);

    // NOOP, unused opcode F, HALT
    Reset = 1'b1;
    preload(2'd0, 8'h00, 16'h0000);
    preload(2'd0, 8'h01, 16'hF000);
    preload(2'd0, 8'h02, 16'h5000);
    start();
    expect_states("halt_seq", 32'h1212129, 7);
    check("halt_flag", 32'(halted), 32'd1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (halted !== 1'b1 || pc_out !== 7'd3 || state_out !== 4'd9 ||
          bus.D_wr || bus.RF_WenA || bus.RF_WenB) bad++;
    end
    check("halt_hold_bad_cycles", 32'(bad), 32'd0);

    // Reset while in LD_RD must abort the load
    Reset = 1'b1;
    tick();
    check("halt_reset_state", 32'(state_out), 32'd0);
    preload(2'd0, 8'h01, 16'h0000);
    preload(2'd0, 8'h02, 16'h0000);
    preload(2'd0, 8'h00, 16'h21A3);
    start();
    expect_states("abort_seq", 32'h125, 3);
    Reset = 1'b1;
    tick();
    check("abort_state", 32'(state_out), 32'd0);
    check("abort_pc", 32'(pc_out), 32'd0);
    check("abort_ir", 32'(ir_out), 32'd0);
    check("abort_wen_a", 32'(bus.RF_WenA), 32'd0);
    tick();
    check("abort_hold_state", 32'(state_out), 32'd0);

    // 128 NOOPs: PC wraps 127 -> 0
    preload(2'd0, 8'h00, 16'h0000);
    start();
    repeat (254) tick();
    check("wrap_state_127", 32'(state_out), 32'd1);
    check("wrap_pc_127", 32'(pc_out), 32'd127);
    repeat (2) tick();
    check("wrap_state_0", 32'(state_out), 32'd1);
    check("wrap_pc_0", 32'(pc_out), 32'd0);

`ifdef SINGLE_STEP_EN
    // Step gating: FETCH holds without Step, one instruction per pulse
    Reset = 1'b1;
    tick();
    Step = 1'b0;
    start();
    repeat (10) tick();
    check("step_hold_state", 32'(state_out), 32'd1);
    check("step_hold_pc", 32'(pc_out), 32'd0);
    for (int p = 1; p <= 2; p++) begin
      Step = 1'b1;
      tick();
      Step = 1'b0;
      repeat (4) tick();
      check("step_state", 32'(state_out), 32'd1);
      check("step_pc", 32'(pc_out), 32'(p));
    end
    Step = 1'b1;
`endif

    Reset = 1'b1;
    tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
